eq_band_mixer: RTL

Parametrised N-band gain-and-mix stage for the graphic equalizer. It sits after the per-band FIR filters. It applies a per-band gain held in an internal register file, sums the gained bands and scales the sum with saturation, then emits one mixed sample per accepted input beat. Gain updates arrive over a valid/ready config port and are optionally ramped per sample to suppress zipper noise.

---
 rtl/eq_band_mixer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/eq_band_mixer.sv
// rtl/eq_band_mixer.sv - N-band per-band gain, sum, shift and saturate mixer
//
// Optional feature macro: EQ_GAIN_RAMP_EN (per-sample gain ramping).
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   cfg_valid/ready   gain write handshake; cfg_band selects band, cfg_level is new target
//   cfg_err           one-cycle pulse after a write to a band index >= NUM_BANDS
//   in_valid, in_data packed signed band samples, band 0 in the LSBs
//   out_valid         mixed sample valid, two cycles after in_valid
//   out_data, out_sat mixed saturated sample and its clip flag
//   settled           every current gain equals its target
module eq_band_mixer #(
    parameter int NUM_BANDS = 3,
    parameter int DATA_W    = 32,
    parameter int GAIN_W    = 8,
    parameter int SUM_SHIFT = 2,
    parameter int RAMP_STEP = 4,
    parameter int BAND_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [BAND_W-1:0]           cfg_band,
    input  logic [GAIN_W-1:0]           cfg_level,
    output logic                        cfg_err,
    input  logic                        in_valid,
    input  logic [NUM_BANDS*DATA_W-1:0] in_data,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_sat,
    output logic                        settled
);

    // Product width: signed sample times zero-extended gain never exceeds this.
    localparam int PW = DATA_W + GAIN_W + 1;
    // Sum width leaves headroom for NUM_BANDS full-scale products.
    localparam int SW = PW + $clog2(NUM_BANDS) + 1;

    localparam logic [GAIN_W-1:0]    UNITY   = {1'b1, {(GAIN_W-1){1'b0}}};
    localparam logic signed [SW-1:0] OUT_MAX = SW'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [SW-1:0] OUT_MIN = ~OUT_MAX;

    logic [GAIN_W-1:0] target_q [NUM_BANDS];
    logic [GAIN_W-1:0] target_d [NUM_BANDS];
    logic [GAIN_W-1:0] cur_q    [NUM_BANDS];
    logic [GAIN_W-1:0] cur_d    [NUM_BANDS];
    logic              settled_d;

    logic cfg_hit;
    logic band_ok;

    assign cfg_hit = cfg_valid & cfg_ready;
    assign band_ok = int'(cfg_band) < NUM_BANDS;

`ifdef EQ_GAIN_RAMP_EN
    // Move c toward t by at most RAMP_STEP, landing exactly on t.
    function automatic logic [GAIN_W-1:0] ramp_toward(input logic [GAIN_W-1:0] c,
                                                      input logic [GAIN_W-1:0] t);
        logic [GAIN_W-1:0] step;
        step = GAIN_W'(RAMP_STEP);
        if (t > c)
            return ((t - c) > step) ? c + step : t;
        else if (c > t)
            return ((c - t) > step) ? c - step : t;
        else
            return c;
    endfunction
`endif

    // Gain register file next state. Ramping reads the pre-write target, so a
    // write coinciding with a beat only steers the following beats.
    always_comb begin
        settled_d = 1'b1;
        for (int b = 0; b < NUM_BANDS; b++) begin
            target_d[b] = target_q[b];
            cur_d[b]    = cur_q[b];
`ifdef EQ_GAIN_RAMP_EN
            if (in_valid)
                cur_d[b] = ramp_toward(cur_q[b], target_q[b]);
`else
            cur_d[b] = target_q[b];
`endif
            if (cfg_hit && band_ok && int'(cfg_band) == b)
                target_d[b] = cfg_level;
            if (cur_d[b] != target_d[b])
                settled_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
            settled   <= 1'b1;
            for (int b = 0; b < NUM_BANDS; b++) begin
                target_q[b] <= UNITY;
                cur_q[b]    <= UNITY;
            end
        end else begin
            cfg_ready <= 1'b1;
            cfg_err   <= cfg_hit & ~band_ok;
            settled   <= settled_d;
            for (int b = 0; b < NUM_BANDS; b++) begin
                target_q[b] <= target_d[b];
                cur_q[b]    <= cur_d[b];
            end
        end
    end

    // Stage 1: per-band gain products, already scaled back by the unity shift.
    logic signed [PW-1:0] smp_ext [NUM_BANDS];
    logic signed [PW-1:0] gain_ext[NUM_BANDS];
    logic signed [PW-1:0] prod_d  [NUM_BANDS];
    logic signed [PW-1:0] prod_q  [NUM_BANDS];
    logic                 v1_q;

    always_comb begin
        for (int b = 0; b < NUM_BANDS; b++) begin
            smp_ext[b]  = PW'($signed(in_data[b*DATA_W +: DATA_W]));
            gain_ext[b] = PW'({1'b0, cur_q[b]});
            prod_d[b]   = (smp_ext[b] * gain_ext[b]) >>> (GAIN_W - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++)
                prod_q[b] <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                for (int b = 0; b < NUM_BANDS; b++)
                    prod_q[b] <= prod_d[b];
            end
        end
    end

    // Stage 2: full-precision sum, arithmetic shift, clip to the output range.
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shifted;
    logic [DATA_W-1:0]    res_d;
    logic                 sat_d;

    always_comb begin
        sum = '0;
        for (int b = 0; b < NUM_BANDS; b++)
            sum = sum + SW'(prod_q[b]);
        shifted = sum >>> SUM_SHIFT;
        sat_d   = 1'b0;
        res_d   = shifted[DATA_W-1:0];
        if (shifted > OUT_MAX) begin
            sat_d = 1'b1;
            res_d = OUT_MAX[DATA_W-1:0];
        end else if (shifted < OUT_MIN) begin
            sat_d = 1'b1;
            res_d = OUT_MIN[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= v1_q;
            out_sat   <= v1_q & sat_d;
            if (v1_q)
                out_data <= res_d;
        end
    end

endmodule
